btn_debounce_array: RTL

BTN_DEBOUNCE_ARRAY -- requirements
Module: btn_debounce_array

---
 rtl/btn_debounce_pkg.sv | 24 ++
 rtl/btn_debounce_array_fsm.sv | 78 +++++++
 rtl/btn_debounce_array.sv | 54 +++++
 3 files changed

// File: rtl/btn_debounce_pkg.sv
// Shared types and defaults for the push-button debounce array.
// Holds the per-channel FSM state encoding and the default tick width.
package btn_debounce_pkg;

  localparam int N_DEFAULT = 20;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } db_state_e;

  // Debounced level is high in ONE and while confirming a release.
  function automatic logic level_of(db_state_e s);
    return (s == ONE) || (s == WAIT0_1) ||
           (s == WAIT0_2) || (s == WAIT0_3);
  endfunction

endpackage

// File: rtl/btn_debounce_array_fsm.sv
// Single-channel debounce FSM with registered level and press pulse.
// A level change must persist across three tick boundaries to commit.
module debounce_fsm
  import btn_debounce_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sw,
  input  logic m_tick,
  output logic db_level,
  output logic db_tick
);

  db_state_e state_q, state_d;
  logic      level_q, level_d;
  logic      tick_q, tick_d;

  // State, level and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
      level_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  // Next state; sw is checked first so a glitch aborts any wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ZERO: begin
        if (sw) state_d = WAIT1_1;
      end
      WAIT1_1: begin
        if (!sw)        state_d = ZERO;
        else if (m_tick) state_d = WAIT1_2;
      end
      WAIT1_2: begin
        if (!sw)        state_d = ZERO;
        else if (m_tick) state_d = WAIT1_3;
      end
      WAIT1_3: begin
        if (!sw)        state_d = ZERO;
        else if (m_tick) state_d = ONE;
      end
      ONE: begin
        if (!sw) state_d = WAIT0_1;
      end
      WAIT0_1: begin
        if (sw)          state_d = ONE;
        else if (m_tick) state_d = WAIT0_2;
      end
      WAIT0_2: begin
        if (sw)          state_d = ONE;
        else if (m_tick) state_d = WAIT0_3;
      end
      WAIT0_3: begin
        if (sw)          state_d = ONE;
        else if (m_tick) state_d = ZERO;
      end
      default: state_d = ZERO;
    endcase
  end

  // Outputs track the next state so they align with state_q.
  always_comb begin
    level_d = level_of(state_d);
    tick_d  = (state_q == WAIT1_3) && (state_d == ONE);
  end

  assign db_level = level_q;
  assign db_tick  = tick_q;

endmodule

// File: rtl/btn_debounce_array.sv
// Multi-channel button debouncer: synchronizers, shared tick counter,
// and one debounce FSM per channel.
module btn_debounce_array
  import btn_debounce_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int N    = N_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] db_level,
  output logic [N_CH-1:0] db_tick
);

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N-1:0]    cnt_q, cnt_d;
  logic            m_tick;

  // Two-stage synchronizer and free-running tick counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next values for synchronizer and counter; counter wraps naturally.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    cnt_d   = cnt_q + 1'b1;
  end

  assign m_tick = &cnt_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_fsm u_fsm (
      .clk      (clk),
      .reset    (reset),
      .sw       (sync2_q[i]),
      .m_tick   (m_tick),
      .db_level (db_level[i]),
      .db_tick  (db_tick[i])
    );
  end

endmodule
